// File: rtl/rng_pkg.sv
// rng_pkg: shared definitions for the random-number arbiter.
//   state_t       FSM encoding used by rng_arbiter (also exported on dbg_state)
//   LFSR_RESET    value the LFSR takes on reset and when seeded with zero
//   LFSR_TAPS     feedback taps q[7]^q[3]^q[2]^q[1] as a bit mask
//   MAX_ATTEMPTS  consecutive rejections before the fold-down fallback
//   lfsr_next()   one LFSR step (shift left, feedback into bit 0)
package rng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] LFSR_RESET   = 8'hBD;
  localparam logic [7:0] LFSR_TAPS    = 8'b1000_1110;
  localparam int         MAX_ATTEMPTS = 16;

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/rng_lfsr8.sv
// rng_lfsr8: 8-bit Fibonacci LFSR with seed load.
//   clk       clock, rising edge
//   rst_n     synchronous active-low reset, q <= LFSR_RESET
//   step      advance one position this cycle
//   load      load load_val this cycle (wins over step)
//   load_val  seed; zero would lock the LFSR, so it maps to LFSR_RESET
//   q         current LFSR contents
module rng_lfsr8
  import rng_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= LFSR_RESET;
    end else if (load) begin
      q <= (load_val == 8'h00) ? LFSR_RESET : load_val;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/rng_arbiter.sv
// rng_arbiter: round-robin arbiter that serves each requester a random word
// in the inclusive range [0, lim_i], drawn from a shared 8-bit LFSR by
// mask-and-reject sampling.
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   seed_load  load seed into the LFSR (only acted on in IDLE)
//   seed       seed value
//   seed_ack   one-cycle pulse after a seed was loaded
//   req        per-requester level request
//   lim        per-requester inclusive upper bound, slice i = lim[i*W +: W]
//   gnt        one-hot one-cycle grant pulse
//   rnd        random result, meaningful while rnd_valid=1
//   rnd_valid  one-cycle pulse coincident with gnt
//   rnd_id     index of the served requester
//   dbg_state  current FSM state (state_t encoding)
//
// Handshake: a requester raises req[i] and holds it (with lim slice i) until
// it sees gnt[i]=1; that single cycle also carries rnd/rnd_valid/rnd_id and
// completes the transaction. Dropping req[i] early does not cancel a
// transaction that has already been granted.
module rng_arbiter
  import rng_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 8,
  localparam int IDW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               seed_load,
  input  logic [W-1:0]       seed,
  output logic               seed_ack,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] lim,
  output logic [N_REQ-1:0]   gnt,
  output logic [W-1:0]       rnd,
  output logic               rnd_valid,
  output logic [IDW-1:0]     rnd_id,
  output logic [1:0]         dbg_state
);

  localparam int CW = IDW + 1;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] id;
  logic [W-1:0]   lim_q;
  logic [4:0]     attempts;
  logic [W-1:0]   result;

  logic [7:0]     lfsr_q;
  logic [W-1:0]   q_w;
  logic [W-1:0]   mask;
  logic [W-1:0]   v;
  logic           any_req;
  logic [IDW-1:0] pick;
  logic [CW-1:0]  cand;

  assign dbg_state = state;

  rng_lfsr8 u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (state == ST_GEN),
    .load     ((state == ST_IDLE) && seed_load),
    .load_val (8'(seed)),
    .q        (lfsr_q)
  );

  assign q_w = W'(lfsr_q);

  // Smallest all-ones value covering lim_q: bit i is set when lim_q has any
  // bit at position i or above.
  always_comb begin
    mask = '0;
    for (int i = 0; i < W; i++) begin
      mask[i] = |(lim_q >> i);
    end
  end

  assign v = q_w & mask;

  // Round-robin pick starting at ptr. Scanning from the farthest offset back
  // to offset 0 lets the closest requesting index overwrite pick last.
  always_comb begin
    any_req = |req;
    pick    = '0;
    cand    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = CW'(ptr) + CW'(i);
      if (cand >= CW'(N_REQ)) cand = cand - CW'(N_REQ);
      if (req[cand[IDW-1:0]]) pick = cand[IDW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      id        <= '0;
      lim_q     <= '0;
      attempts  <= '0;
      result    <= '0;
      gnt       <= '0;
      rnd_valid <= 1'b0;
      seed_ack  <= 1'b0;
      rnd       <= '0;
      rnd_id    <= '0;
    end else begin
      gnt       <= '0;
      rnd_valid <= 1'b0;
      seed_ack  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (seed_load) begin
            seed_ack <= 1'b1;
          end else if (any_req) begin
            id       <= pick;
            lim_q    <= lim[pick*W +: W];
            attempts <= '0;
            state    <= ST_GEN;
          end
        end
        ST_GEN: begin
          if (v <= lim_q) begin
            result <= v;
            state  <= ST_DONE;
          end else if (attempts == 5'(MAX_ATTEMPTS - 1)) begin
            // Fold the rejected sample back into range: v <= mask <= 2*lim+1,
            // so v-(lim+1) <= lim. This caps the time spent in GEN.
            result <= v - lim_q - W'(1);
            state  <= ST_DONE;
          end else begin
            attempts <= attempts + 5'd1;
          end
        end
        ST_DONE: begin
          rnd       <= result;
          rnd_valid <= 1'b1;
          rnd_id    <= id;
          gnt[id]   <= 1'b1;
          ptr       <= (id == IDW'(N_REQ - 1)) ? '0 : id + 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rng_arbiter.sv
// tb_rng_arbiter: directed self-checking bench for rng_arbiter.
// Expected random words are hand-derived from the LFSR sequence
// BD -> 7B -> F6 -> ED and 5A -> B4.
module tb_rng_arbiter;

  localparam int N_REQ = 4;
  localparam int W     = 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               seed_load = 1'b0;
  logic [W-1:0]       seed      = '0;
  logic [N_REQ-1:0]   req       = '0;
  logic [N_REQ*W-1:0] lim       = '0;
  logic               seed_ack;
  logic [N_REQ-1:0]   gnt;
  logic [W-1:0]       rnd;
  logic               rnd_valid;
  logic [1:0]         rnd_id;
  logic [1:0]         dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  rng_arbiter #(.N_REQ(N_REQ), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (seed_load),
    .seed      (seed),
    .seed_ack  (seed_ack),
    .req       (req),
    .lim       (lim),
    .gnt       (gnt),
    .rnd       (rnd),
    .rnd_valid (rnd_valid),
    .rnd_id    (rnd_id),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0;
    seed_load = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits (sampling on negedges) for rnd_valid, at most 40 cycles.
  task automatic wait_valid(output bit seen, output int lat);
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (rnd_valid) seen = 1'b1;
    end
  endtask

  // One full transaction for requester r; checks result, id, grant,
  // latency in cycles, and that the pulse lasts exactly one cycle.
  task automatic txn(input string tag, input int r, input logic [W-1:0] l,
                     input logic [W-1:0] exp_rnd, input int exp_lat);
    bit seen;
    int lat;
    req[r] = 1'b1;
    lim[r*W +: W] = l;
    exp_q.push_back(exp_rnd);
    wait_valid(seen, lat);
    check({tag, "_seen"}, 32'(seen), 32'd1);
    check({tag, "_rnd"}, 32'(rnd), 32'(exp_q.pop_front()));
    check({tag, "_id"}, 32'(rnd_id), 32'(r));
    check({tag, "_gnt"}, 32'(gnt), 32'(1) << r);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    req[r] = 1'b0;
    @(negedge clk);
    check({tag, "_pulse"}, {27'd0, rnd_valid, gnt}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit seen;
    int lat;

    // Reset state
    do_reset();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_valid", 32'(rnd_valid), 32'd0);
    check("rst_ack", 32'(seed_ack), 32'd0);
    check("rst_rnd", 32'(rnd), 32'd0);
    check("rst_id", 32'(rnd_id), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // Full-range draws: first two LFSR values, one GEN cycle each
    txn("full0", 0, 8'hFF, 8'hBD, 3);
    txn("full1", 0, 8'hFF, 8'h7B, 3);

    // lim 0F: mask 0F, BD&0F=0D accepted at once
    do_reset();
    txn("lim0f", 0, 8'h0F, 8'h0D, 3);

    // lim 0A: 0D and 0B rejected, F6&0F=06 accepted after 3 GEN cycles
    do_reset();
    txn("lim0a", 0, 8'h0A, 8'h06, 5);

    // Round robin with all four requesting, each dropped on its own grant
    do_reset();
    lim = {4{8'hFF}};
    req = 4'b1111;
    exp_q.push_back(8'hBD);
    exp_q.push_back(8'h7B);
    exp_q.push_back(8'hF6);
    exp_q.push_back(8'hED);
    for (int i = 0; i < 4; i++) begin
      wait_valid(seen, lat);
      check("rr_seen", 32'(seen), 32'd1);
      check("rr_gnt", 32'(gnt), 32'(1) << i);
      check("rr_id", 32'(rnd_id), 32'(i));
      check("rr_rnd", 32'(rnd), 32'(exp_q.pop_front()));
      check("rr_lat", 32'(lat), 32'd3);
      req = req & ~gnt;
    end
    req = '0;

    // Seed 0 maps to BD
    do_reset();
    seed_load = 1'b1;
    seed = 8'h00;
    @(negedge clk);
    check("seed0_ack", 32'(seed_ack), 32'd1);
    seed_load = 1'b0;
    @(negedge clk);
    check("seed0_ack_off", 32'(seed_ack), 32'd0);
    txn("seed0", 0, 8'hFF, 8'hBD, 3);

    // seed_load wins over a simultaneous request
    seed_load = 1'b1;
    seed = 8'h5A;
    req[0] = 1'b1;
    lim[7:0] = 8'hFF;
    @(negedge clk);
    check("seed5a_ack", 32'(seed_ack), 32'd1);
    check("seed5a_idle", 32'(dbg_state), 32'd0);
    seed_load = 1'b0;
    @(negedge clk);
    check("seed5a_gen", 32'(dbg_state), 32'd1);
    // seed_load while busy must be ignored and not buffered
    seed_load = 1'b1;
    seed = 8'h33;
    @(negedge clk);
    check("busy_ack_a", 32'(seed_ack), 32'd0);
    @(negedge clk);
    check("busy_ack_b", 32'(seed_ack), 32'd0);
    check("busy_valid", 32'(rnd_valid), 32'd1);
    check("busy_rnd", 32'(rnd), 32'h5A);
    check("busy_gnt", 32'(gnt), 32'd1);
    seed_load = 1'b0;
    req[0] = 1'b0;
    @(negedge clk);
    txn("after_busy", 0, 8'hFF, 8'hB4, 3);

    // Reset in the middle of GEN aborts without a grant
    do_reset();
    req[0] = 1'b1;
    lim[7:0] = 8'h0A;
    @(negedge clk);
    @(negedge clk);
    check("abort_in_gen", 32'(dbg_state), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_gnt", 32'(gnt), 32'd0);
    check("abort_valid", 32'(rnd_valid), 32'd0);
    check("abort_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    txn("abort_redo", 0, 8'hFF, 8'hBD, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
